// File: rtl/anim_pkg.sv
// anim_pkg: shared mode/state types and default ROM offsets for sprite animators
package anim_pkg;
  typedef enum logic [1:0] {LOOP = 2'd0, PINGPONG = 2'd1, ONESHOT = 2'd2, RSVD = 2'd3} anim_mode_t;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} anim_state_t;
  localparam int unsigned DEF_BASE_OFFSET = 3264;
  localparam int unsigned DEF_IDLE_OFFSET = 0;
endpackage

// File: rtl/anim_offset_calc.sv
// anim_offset_calc: registered sprite-ROM offset = base + idx*height*width, idle offset outside RUN/DONE
module anim_offset_calc
  import anim_pkg::*;
#(
  parameter int          IDX_W       = 3,
  parameter int          OFF_W       = 32,
  parameter int unsigned BASE_OFFSET = DEF_BASE_OFFSET,
  parameter int unsigned IDLE_OFFSET = DEF_IDLE_OFFSET
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [IDX_W-1:0]  idx,
  input  logic [9:0]        height,
  input  logic [9:0]        width,
  input  anim_state_t       state,
  output logic [OFF_W-1:0]  offset
);
  localparam int PW = (IDX_W + 21 > 33) ? IDX_W + 21 : 33;
  logic [19:0]   size;
  logic [PW-1:0] full;
  // full-width multiply-add; size inputs are used live
  always_comb begin
    size = 20'(height) * 20'(width);
    full = PW'(BASE_OFFSET) + PW'(idx) * PW'(size);
  end
  // offset register follows state/idx one clock later, every clock
  always_ff @(posedge Clk)
    offset <= (Reset || state == IDLE) ? OFF_W'(IDLE_OFFSET) : OFF_W'(full);
endmodule

// File: rtl/sprite_anim_seq.sv
// sprite_anim_seq: tick-gated sprite frame sequencer with loop/ping-pong/one-shot playback
module sprite_anim_seq
  import anim_pkg::*;
#(
  parameter int          MAX_FRAMES  = 8,
  parameter int          IDX_W       = 3,
  parameter int          HOLD_W      = 4,
  parameter int          OFF_W       = 32,
  parameter int unsigned BASE_OFFSET = DEF_BASE_OFFSET,
  parameter int unsigned IDLE_OFFSET = DEF_IDLE_OFFSET
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_tick,
  input  logic              moving,
  input  logic [1:0]        mode,
  input  logic [IDX_W:0]    num_frames,
  input  logic [HOLD_W-1:0] hold,
  input  logic [9:0]        spriteHeight,
  input  logic [9:0]        spriteWidth,
  output logic [OFF_W-1:0]  animationOffset,
  output logic [IDX_W-1:0]  frame_idx,
  output logic              anim_busy,
  output logic              anim_done
);
  localparam logic [IDX_W:0] MAXN = (IDX_W + 1)'(MAX_FRAMES);
  anim_state_t       state;
  anim_mode_t        mode_l;
  logic [IDX_W:0]    n_l, n_eff;
  logic [HOLD_W-1:0] hold_l, hold_cnt;
  logic              dir, up, at_last, pp, os, nxt_dir, to_done;
  logic [IDX_W-1:0]  last, inc, dec, nxt_idx;
  // next frame index/direction for one advance, by latched mode
  always_comb begin
    n_eff   = (num_frames == '0) ? (IDX_W + 1)'(1) : (num_frames > MAXN) ? MAXN : num_frames;
    last    = IDX_W'(n_l - (IDX_W + 1)'(1));
    at_last = frame_idx == last;
    pp      = mode_l == PINGPONG;
    os      = mode_l == ONESHOT;
    inc     = frame_idx + IDX_W'(1);
    dec     = frame_idx - IDX_W'(1);
    up      = dir ? frame_idx == '0 : !at_last;
    nxt_idx = pp ? ((last == '0) ? '0 : up ? inc : dec) : at_last ? (os ? frame_idx : '0) : inc;
    nxt_dir = pp ? (last != '0 && !up) : dir;
    to_done = os && at_last;
  end
  // sequencer FSM, hold counter and config latch, advancing only on frame_tick
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      frame_idx <= '0;
      hold_cnt  <= '0;
      dir       <= 1'b0;
      mode_l    <= LOOP;
      n_l       <= (IDX_W + 1)'(1);
      hold_l    <= '0;
    end else if (frame_tick) begin
      case (state)
        IDLE: if (moving) begin
          state     <= RUN;
          frame_idx <= '0;
          hold_cnt  <= '0;
          dir       <= 1'b0;
          mode_l    <= anim_mode_t'(mode);
          n_l       <= n_eff;
          hold_l    <= hold;
        end
        RUN: if (!moving) begin
          state     <= IDLE;
          frame_idx <= '0;
          hold_cnt  <= '0;
          dir       <= 1'b0;
        end else if (hold_cnt != hold_l) begin
          hold_cnt  <= hold_cnt + HOLD_W'(1);
        end else begin
          hold_cnt  <= '0;
          frame_idx <= nxt_idx;
          dir       <= nxt_dir;
          if (to_done) state <= DONE;
        end
        default: if (!moving) begin
          state     <= IDLE;
          frame_idx <= '0;
          hold_cnt  <= '0;
          dir       <= 1'b0;
        end
      endcase
    end
  end
  assign anim_busy = state == RUN;
  assign anim_done = state == DONE;
  anim_offset_calc #(
    .IDX_W(IDX_W), .OFF_W(OFF_W), .BASE_OFFSET(BASE_OFFSET), .IDLE_OFFSET(IDLE_OFFSET)
  ) u_off (
    .Clk(Clk), .Reset(Reset), .idx(frame_idx), .height(spriteHeight), .width(spriteWidth),
    .state(state), .offset(animationOffset)
  );
endmodule

// File: doc/sprite_anim_seq.md
Name: sprite_anim_seq

Overview:
Parametrised sprite animation sequencer, the next generation of the player walk-cycle animator. It steps a frame index at a programmable rate and converts it to a sprite-ROM byte offset for the sprite drawing logic. It supports loop, ping-pong and one-shot playback, a runtime frame count, and an explicit done/idle status. It runs on the system clock, with a per-video-frame enable; the video frame signal is no longer used as a clock.

Parameters:
MAX_FRAMES, 8, maximum frames per animation strip (≥1)
IDX_W, 3, frame index width, equal to clog2(MAX_FRAMES), minimum 1
HOLD_W, 4, width of the hold (ticks-per-frame) field
OFF_W, 32, width of the offset output
BASE_OFFSET, 3264, ROM offset of frame 0 of the strip
IDLE_OFFSET, 0, ROM offset of the standing/idle sprite

Ports:
Clk, in, 1, system clock
Reset, in, 1, synchronous active-high reset
frame_tick, in, 1, one-Clk pulse per video frame; all sequencing advances only on it
moving, in, 1, animation request; level, sampled on frame_tick
mode, in, 2, 0=LOOP, 1=PINGPONG, 2=ONESHOT, 3=reserved (treated as LOOP)
num_frames, in, IDX_W+1, frames in the strip
hold, in, HOLD_W, frame advances after hold+1 ticks
spriteHeight, in, 10, sprite height in pixels
spriteWidth, in, 10, sprite width in pixels
animationOffset, out, OFF_W, sprite-ROM offset of the current frame
frame_idx, out, IDX_W, current frame index
anim_busy, out, 1, high in RUN
anim_done, out, 1, high in DONE (one-shot finished)

Behaviour:
- Reset: synchronous, active-high. It overrides frame_tick. Resulting values: state=IDLE, frame_idx=0, hold_cnt=0, dir=up, animationOffset=IDLE_OFFSET, anim_busy=0, anim_done=0. Reset in mid-run gives the same result with no partial frame.
- With frame_tick low, all state is frozen except the offset pipeline register.
- Latched config: mode, num_frames and hold are latched on the tick that takes IDLE→RUN. Later changes are ignored until the block returns to IDLE.
- Effective frame count: N = num_frames; 0 is treated as 1; values above MAX_FRAMES are clamped to MAX_FRAMES.
- States: IDLE, RUN, DONE.
  - IDLE: on tick with moving=1 → RUN, with frame_idx=0, hold_cnt=0, dir=up.
  - RUN, tick with moving=0 → IDLE and frame_idx=0. This has priority over everything else.
  - RUN, tick with moving=1 and hold_cnt≠hold_latched → hold_cnt+1.
  - RUN, tick with moving=1 and hold_cnt==hold_latched → hold_cnt=0 and the frame advances.
- Frame advance by mode:
  - LOOP: idx+1, wrapping N-1→0.
  - PINGPONG: dir=up goes idx+1, and flips to down at N-1. dir=down goes idx-1, and flips to up at 0. Each endpoint is shown once per pass. N=5 gives 0,1,2,3,4,3,2,1,0,1… With N=1 the index stays at 0. With N=2 the sequence is 0,1,0,1.
  - ONESHOT: idx+1. Advancing from N-1 → DONE, and idx stays at N-1.
- DONE: holds the last frame. On tick with moving=0 → IDLE. moving=1 stays in DONE; replay needs moving to drop first.
- Offset arithmetic:
  - size = spriteHeight*spriteWidth, 20-bit unsigned.
  - In RUN/DONE: animationOffset = BASE_OFFSET + frame_idx*size, computed at full width then zero-extended/truncated to OFF_W.
  - In IDLE: animationOffset = IDLE_OFFSET.
- Offset latency: animationOffset is registered, updated every Clk, and lags frame_idx/state by exactly 1 Clk. Size inputs are sampled live.
- Status outputs: anim_busy and anim_done are combinational decodes of state, with 0 latency.

Decomposition:
- anim_pkg holds:
  - anim_mode_t enum (LOOP, PINGPONG, ONESHOT, RSVD)
  - anim_state_t enum (IDLE, RUN, DONE)
  - default BASE_OFFSET/IDLE_OFFSET constants
- Sub-module anim_offset_calc: a registered multiply-add (idx, height, width, state → offset). It can be reused by the enemy animators.
- The sequencer FSM, hold counter and direction logic stay in sprite_anim_seq.

Test Plan:
- Ping-pong walk cycle: mode=1, N=5, hold=3, 20×24 sprite, moving=1 for 40 ticks → frame_idx sequence 0,1,2,3,4,3,2,1,0,1, each held 4 ticks. Offsets are 3264+480·idx, appearing 1 Clk after the idx change.
- Loop: mode=0, N=3, hold=0 → idx 0,1,2,0,1 on successive ticks. Then assert Reset mid-run → idx=0, offset=IDLE_OFFSET, busy=0 next Clk.
- One-shot: mode=2, N=4, hold=1 → idx 0..3 over 8 ticks, then anim_done=1 with idx=3. Holding moving=1 keeps DONE; dropping moving → IDLE on the next tick.
- Stop mid-frame: moving falls with hold_cnt=2 at idx=3 → IDLE on that tick, offset=IDLE_OFFSET 1 Clk later. Reasserting moving restarts at idx=0.
- Boundary counts:
  - num_frames=0 and num_frames=1, all modes → idx stays 0 (ONESHOT enters DONE after hold+1 ticks).
  - num_frames=15 → clamped to 8 (idx never exceeds 7).
- Config latching and tick gating: change mode/hold during RUN → no effect until after IDLE. frame_tick held low for 100 Clk → idx and hold_cnt unchanged.
